dac_uart_cmd_fsm: RTL and testbench

DAC_UART_CMD_FSM -- requirements
Module: dac_uart_cmd_fsm

---
 rtl/dac_uart_cmd_fsm_pkg.sv | 14 +
 rtl/dac_uart_cmd_fsm_cmd_timeout_ctr.sv | 19 +
 rtl/dac_uart_cmd_fsm.sv | 95 +++++++++
 tb/tb_dac_uart_cmd_fsm.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dac_uart_cmd_fsm_pkg.sv
// dac_uart_cmd_fsm_pkg: shared state encoding and ASCII reply constants for the UART-to-I2C DAC command block.
package dac_uart_cmd_fsm_pkg;
  typedef enum logic [2:0] {
    IDLE, GET_CH, GET_BITS, WAIT_IDLE, LOAD, WAIT_BUSY, WAIT_DONE, REPLY
  } state_t;
  localparam logic [7:0] ASCII_0 = 8'd48;
  localparam logic [7:0] ASCII_1 = 8'd49;
  localparam logic [7:0] ASCII_A = 8'd65;
  localparam logic [7:0] ASCII_N = 8'd78;
  localparam logic [7:0] ASCII_T = 8'd84;
  function automatic logic is_wait(input state_t s);
    return s inside {WAIT_IDLE, WAIT_BUSY, WAIT_DONE};
  endfunction
endpackage

// File: rtl/dac_uart_cmd_fsm_cmd_timeout_ctr.sv
// cmd_timeout_ctr: loadable saturating down-counter; expired is high once the count reaches zero.
module cmd_timeout_ctr #(
  parameter int WIDTH = 10,
  parameter logic [WIDTH-1:0] LOAD_VAL = '0
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic expired
);
  logic [WIDTH-1:0] cnt;
  always_ff @(posedge clk) begin
    if (rst) cnt <= '0;
    else if (load) cnt <= LOAD_VAL;
    else if (en && cnt != '0) cnt <= cnt - WIDTH'(1);
  end
  assign expired = cnt == '0;
endmodule

// File: rtl/dac_uart_cmd_fsm.sv
// dac_uart_cmd_fsm: parses "V<ch><bits>" UART commands, writes the code to a DAC over I2C and replies A/N/T.
module dac_uart_cmd_fsm
  import dac_uart_cmd_fsm_pkg::*;
#(
  parameter int DAC_BITS = 10,
  parameter int LSB_PAD = 2,
  parameter int NUM_CH = 4,
  parameter logic [6:0] BASE_ADDR = 7'h0D,
  parameter logic [7:0] CMD_CHAR = 8'd86,
  parameter int TIMEOUT = 1023
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  UART_Rx,
  input  logic        UART_DataReady,
  output logic [7:0]  UART_Tx,
  output logic        UART_TxValid,
  output logic [6:0]  I2Caddr,
  output logic [15:0] I2Cdata,
  output logic        I2Cbytes,
  output logic        I2Cr_w,
  output logic        I2C_load,
  input  logic        I2CBusy,
  input  logic        I2CDataReady
);
  localparam int CW = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
  localparam int BW = $clog2(DAC_BITS + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [7:0] CH_END = 8'(ASCII_0 + NUM_CH);
  state_t state, next;
  logic [CW-1:0] channel;
  logic [BW-1:0] bit_cnt;
  logic [DAC_BITS-1:0] sr;
  logic [7:0] reply;
  logic [NUM_CH-1:0][DAC_BITS-1:0] shadow;
  logic expired, ch_ok, bit_ok, last_bit, done_ok, unused;
  assign ch_ok = UART_Rx >= ASCII_0 && UART_Rx < CH_END && UART_Rx != CMD_CHAR;
  assign bit_ok = (UART_Rx == ASCII_0 || UART_Rx == ASCII_1) && UART_Rx != CMD_CHAR;
  assign last_bit = bit_cnt == BW'(DAC_BITS - 1);
  assign done_ok = state == WAIT_DONE && !I2CBusy;
  cmd_timeout_ctr #(.WIDTH(TW), .LOAD_VAL(TW'(TIMEOUT - 1))) u_timeout (
    .clk(clk),
    .rst(rst),
    .load(is_wait(next) && next != state),
    .en(is_wait(state)),
    .expired(expired)
  );
  always_ff @(posedge clk) state <= rst ? IDLE : next;
  always_comb begin
    next = state;
    case (state)
      IDLE:      next = UART_DataReady && UART_Rx == CMD_CHAR ? GET_CH : IDLE;
      GET_CH:    next = !UART_DataReady ? GET_CH : ch_ok ? GET_BITS : REPLY;
      GET_BITS:  next = !UART_DataReady ? GET_BITS : !bit_ok ? REPLY : last_bit ? WAIT_IDLE : GET_BITS;
      WAIT_IDLE: next = !I2CBusy ? LOAD : expired ? REPLY : WAIT_IDLE;
      LOAD:      next = WAIT_BUSY;
      WAIT_BUSY: next = I2CBusy ? WAIT_DONE : expired ? REPLY : WAIT_BUSY;
      WAIT_DONE: next = !I2CBusy || expired ? REPLY : WAIT_DONE;
      default:   next = IDLE;
    endcase
  end
  // channel and code stay frozen outside GET_CH/GET_BITS, which keeps the I2C word stable through the transfer
  always_ff @(posedge clk) begin
    if (rst) begin
      channel <= '0;
      bit_cnt <= '0;
      sr <= '0;
      reply <= '0;
      shadow <= '0;
    end else begin
      if (state == GET_CH && UART_DataReady && ch_ok) begin
        channel <= CW'(UART_Rx - ASCII_0);
        bit_cnt <= '0;
        sr <= '0;
      end
      if (state == GET_BITS && UART_DataReady && bit_ok) begin
        sr <= DAC_BITS'({sr, UART_Rx[0]});
        bit_cnt <= bit_cnt + BW'(1);
      end
      if (done_ok) shadow[channel] <= sr;
      if (next == REPLY && state != REPLY) reply <= done_ok ? ASCII_A : is_wait(state) ? ASCII_T : ASCII_N;
    end
  end
  always_comb begin
    UART_TxValid = state == REPLY;
    UART_Tx = state == REPLY ? reply : 8'd0;
    I2C_load = state == LOAD;
  end
  assign I2Caddr = BASE_ADDR + 7'(channel);
  assign I2Cdata = 16'(sr) << LSB_PAD;
  assign I2Cbytes = 1'b1;
  assign I2Cr_w = 1'b0;
  // shadow is internal-only state and the I2C data-ready flag is not needed by this block
  assign unused = ^{I2CDataReady, shadow};
endmodule

// File: tb/tb_dac_uart_cmd_fsm.sv
// tb_dac_uart_cmd_fsm: vector table, randomized commands against an intent-level model, and timing corner cases.
module tb_dac_uart_cmd_fsm;
  logic clk = 0, rst = 1;
  logic [7:0] UART_Rx = 0;
  logic UART_DataReady = 0, I2CBusy = 0, busy_t = 0, i2c_dr = 0;
  logic [7:0] tx, t_tx;
  logic tx_valid, t_tx_valid, load, t_load, bytes_o, t_bytes, r_w, t_r_w;
  logic [6:0] addr, t_addr;
  logic [15:0] data, t_data;
  int checks = 0, failures = 0, cyc = 0;
  logic [22:0] loads[$];
  logic [7:0] replies[$];
  int m_load_cyc, m_reply_cyc, t_load_cyc, t_reply_cyc, t_loads;
  logic [7:0] t_reply;
  logic [9:0] exp_shadow[4];

  dac_uart_cmd_fsm dut (
    .clk(clk), .rst(rst), .UART_Rx(UART_Rx), .UART_DataReady(UART_DataReady),
    .UART_Tx(tx), .UART_TxValid(tx_valid), .I2Caddr(addr), .I2Cdata(data),
    .I2Cbytes(bytes_o), .I2Cr_w(r_w), .I2C_load(load), .I2CBusy(I2CBusy), .I2CDataReady(i2c_dr)
  );
  dac_uart_cmd_fsm #(.TIMEOUT(15)) dut_t (
    .clk(clk), .rst(rst), .UART_Rx(UART_Rx), .UART_DataReady(UART_DataReady),
    .UART_Tx(t_tx), .UART_TxValid(t_tx_valid), .I2Caddr(t_addr), .I2Cdata(t_data),
    .I2Cbytes(t_bytes), .I2Cr_w(t_r_w), .I2C_load(t_load), .I2CBusy(busy_t), .I2CDataReady(i2c_dr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (load) begin loads.push_back({addr, data}); m_load_cyc = cyc; end
    if (tx_valid) begin replies.push_back(tx); m_reply_cyc = cyc; end
    if (t_load) begin t_loads++; t_load_cyc = cyc; end
    if (t_tx_valid) begin t_reply = t_tx; t_reply_cyc = cyc; end
  end

  typedef struct packed {
    logic [127:0] cmd;
    logic [7:0] reply;
    logic [6:0] addr;
    logic [15:0] data;
  } vec_t;
  vec_t tbl[13];

  function automatic logic [127:0] s(input string x);
    logic [127:0] v = '0;
    for (int i = 0; i < x.len(); i++) v = {v[119:0], x[i]};
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    UART_Rx = b;
    UART_DataReady = 1;
    tick;
    UART_DataReady = 0;
    tick;
  endtask

  task automatic send_str(input logic [127:0] v);
    for (int i = 15; i >= 0; i--) if (v[i*8 +: 8] != 0) send_byte(v[i*8 +: 8]);
  endtask

  task automatic send_cmd(input int ch, input logic [9:0] code);
    send_byte(8'd86);
    send_byte(8'(48 + ch));
    for (int j = 9; j >= 0; j--) send_byte(code[j] ? 8'd49 : 8'd48);
  endtask

  task automatic clear_q;
    loads.delete();
    replies.delete();
  endtask

  task automatic do_reset;
    rst = 1;
    repeat (2) tick;
    rst = 0;
    clear_q();
    t_loads = 0; t_reply = 0; t_load_cyc = 0; t_reply_cyc = 0;
    for (int c = 0; c < 4; c++) exp_shadow[c] = 0;
  endtask

  // behaves like an I2C master: busy rises dly cycles after the load and stays up for len cycles
  task automatic finish_cmd(input int dly, input int len, input bit junk);
    int k = -1;
    bit done = 0;
    I2CBusy = 0;
    for (int t = 0; t < 3000 && !done; t++) begin
      if (k < 0 && loads.size() > 0) k = 0;
      if (k >= 0) k++;
      I2CBusy = k > dly && k <= dly + len;
      UART_DataReady = junk && (k == 2 || k == dly + 3);
      UART_Rx = 8'($urandom);
      done = replies.size() > 0;
      tick;
    end
    UART_DataReady = 0;
    I2CBusy = 0;
    check("reply_seen", 32'(done), 1);
  endtask

  task automatic expect_cmd(input logic [7:0] rep, input logic [6:0] a, input logic [15:0] d);
    bit has_load = rep == 8'd65;
    if (has_load) exp_shadow[int'(a - 7'h0D)] = 10'(d >> 2);
    check("reply_count", replies.size(), 1);
    check("reply_byte", replies.size() > 0 ? 32'(replies[0]) : 32'hFFFF, rep);
    check("load_count", loads.size(), 32'(has_load));
    check("load_word", loads.size() > 0 ? 32'(loads[0]) : 0, has_load ? 32'({a, d}) : 0);
    for (int c = 0; c < 4; c++) check($sformatf("shadow%0d", c), 32'(dut.shadow[c]), 32'(exp_shadow[c]));
  endtask

  initial begin
    logic [7:0] b;
    logic [9:0] code;
    int ch, mode, p, start;
    bit ok;
    tbl[0]  = '{s("V21000000001"), 8'd65, 7'h0F, 16'h0804};
    tbl[1]  = '{s("V110x"), 8'd78, 7'h00, 16'h0000};
    tbl[2]  = '{s("V9"), 8'd78, 7'h00, 16'h0000};
    tbl[3]  = '{s("V01111111111"), 8'd65, 7'h0D, 16'h0FFC};
    tbl[4]  = '{s("V30000000000"), 8'd65, 7'h10, 16'h0000};
    tbl[5]  = '{s("V30101010101"), 8'd65, 7'h10, 16'h0554};
    tbl[6]  = '{s("V1V"), 8'd78, 7'h00, 16'h0000};
    tbl[7]  = '{s("xV10000000011"), 8'd65, 7'h0E, 16'h000C};
    tbl[8]  = '{s("V4"), 8'd78, 7'h00, 16'h0000};
    tbl[9]  = '{s("V/"), 8'd78, 7'h00, 16'h0000};
    tbl[10] = '{s("V01111122"), 8'd78, 7'h00, 16'h0000};
    tbl[11] = '{s("V21111111112"), 8'd78, 7'h00, 16'h0000};
    tbl[12] = '{s("V10000000001"), 8'd65, 7'h0E, 16'h0004};

    repeat (3) tick;
    check("rst_tx", 32'(tx), 0);
    check("rst_tx_valid", 32'(tx_valid), 0);
    check("rst_load", 32'(load), 0);
    check("rst_addr", 32'(addr), 32'h0D);
    check("rst_data", 32'(data), 0);
    check("tie_bytes", 32'(bytes_o), 1);
    check("tie_r_w", 32'(r_w), 0);
    do_reset();

    for (int i = 0; i < 13; i++) begin
      clear_q();
      send_str(tbl[i].cmd);
      finish_cmd(2, 20, 0);
      expect_cmd(tbl[i].reply, tbl[i].addr, tbl[i].data);
    end

    for (int n = 0; n < 40; n++) begin
      clear_q();
      ch = $urandom_range(0, 3);
      code = 10'($urandom);
      mode = $urandom_range(0, 3);
      p = $urandom_range(0, 9);
      i2c_dr = 1'($urandom);
      repeat ($urandom_range(0, 2)) begin
        do b = 8'($urandom); while (b == 8'd86);
        send_byte(b);
      end
      send_byte(8'd86);
      if (mode == 2) begin
        do b = 8'($urandom); while (b >= 8'd48 && b <= 8'd51);
        send_byte(b);
      end else begin
        send_byte(8'(48 + ch));
        for (int j = 9; j >= 0; j--) begin
          if (mode == 3 && j == p) begin
            do b = 8'($urandom); while (b == 8'd48 || b == 8'd49);
            send_byte(b);
            break;
          end
          send_byte(code[j] ? 8'd49 : 8'd48);
        end
      end
      finish_cmd($urandom_range(1, 4), $urandom_range(5, 40), 1);
      ok = mode < 2;
      expect_cmd(ok ? 8'd65 : 8'd78, ok ? 7'(13 + ch) : 7'd0, ok ? 16'(code) << 2 : 16'd0);
    end
    i2c_dr = 0;

    do_reset();
    send_cmd(0, 10'h155);
    for (int t = 0; t < 2000 && replies.size() == 0; t++) tick;
    check("to15_reply", 32'(t_reply), 84);
    check("to15_latency", 32'(t_reply_cyc - t_load_cyc), 16);
    check("to15_loads", 32'(t_loads), 1);
    check("to15_shadow0", 32'(dut_t.shadow[0]), 0);
    check("to1023_reply", replies.size() > 0 ? 32'(replies[0]) : 0, 84);
    check("to1023_latency", 32'(m_reply_cyc - m_load_cyc), 1024);
    check("to1023_shadow0", 32'(dut.shadow[0]), 0);

    do_reset();
    I2CBusy = 1;
    start = cyc;
    send_cmd(2, 10'h201);
    send_byte(8'd86);
    send_byte(8'd48);
    while (cyc - start < 50) tick;
    check("load_while_busy", loads.size(), 0);
    I2CBusy = 0;
    finish_cmd(2, 10, 0);
    expect_cmd(8'd65, 7'h0F, 16'h0804);
    clear_q();
    send_cmd(1, 10'h2AA);
    finish_cmd(1, 8, 0);
    expect_cmd(8'd65, 7'h0E, 16'h0AA8);

    do_reset();
    send_cmd(3, 10'h0F0);
    for (int t = 0; t < 50 && loads.size() == 0; t++) tick;
    check("wd_load_seen", loads.size(), 1);
    repeat (2) tick;
    I2CBusy = 1;
    repeat (6) tick;
    rst = 1;
    tick;
    check("wd_rst_tx", 32'(tx), 0);
    check("wd_rst_tx_valid", 32'(tx_valid), 0);
    check("wd_rst_load", 32'(load), 0);
    check("wd_rst_addr", 32'(addr), 32'h0D);
    check("wd_rst_data", 32'(data), 0);
    rst = 0;
    I2CBusy = 0;
    clear_q();
    for (int c = 0; c < 4; c++) exp_shadow[c] = 0;
    repeat (40) tick;
    check("wd_no_reply", replies.size(), 0);
    send_cmd(0, 10'h3C3);
    finish_cmd(2, 6, 0);
    expect_cmd(8'd65, 7'h0D, 16'h0F0C);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
